// File: rtl/jelly3_cdc_gray_dest.sv
// Destination half of a gray-code CDC: DEST_SYNC_FF-deep synchronizer chain plus gray-to-binary decode.
// Optional step checker enabled by JELLY3_CDC_GRAY_LOSSLESS_CHK_EN (adds sticky dest_gray_err).
module jelly3_cdc_gray_dest #(
  parameter int    WIDTH          = 8,
  parameter int    DEST_SYNC_FF   = 4,
  parameter string DEVICE         = "RTL",
  parameter int    SIM_ASSERT_CHK = 0
) (
  input  logic             dest_clk,
  input  logic             dest_rst_n,
  input  logic [WIDTH-1:0] src_in_gray,
  output logic [WIDTH-1:0] dest_out_bin,
  output logic [WIDTH-1:0] dest_out_gray
`ifdef JELLY3_CDC_GRAY_LOSSLESS_CHK_EN
  ,
  output logic             dest_gray_err
`endif
);

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [DEST_SYNC_FF-1:0][WIDTH-1:0] sync_d;
  logic [DEST_SYNC_FF-1:0][WIDTH-1:0] sync_q;

  // Next chain contents: stage 0 captures the foreign word, every later stage shifts.
  always_comb begin
    sync_d = {sync_q[DEST_SYNC_FF-2:0], src_in_gray};
  end

  // Vendor builds tag the chain so placement keeps the stages together.
  if (DEVICE != "RTL") begin : g_async_reg
    (* ASYNC_REG = "TRUE" *) logic [DEST_SYNC_FF-1:0][WIDTH-1:0] chain_q;

    // Synchronizer chain register, cleared asynchronously.
    always_ff @(posedge dest_clk or negedge dest_rst_n) begin
      if (!dest_rst_n) begin
        chain_q <= '0;
      end else begin
        chain_q <= sync_d;
      end
    end

    assign sync_q = chain_q;
  end else begin : g_plain
    logic [DEST_SYNC_FF-1:0][WIDTH-1:0] chain_q;

    // Synchronizer chain register, cleared asynchronously.
    always_ff @(posedge dest_clk or negedge dest_rst_n) begin
      if (!dest_rst_n) begin
        chain_q <= '0;
      end else begin
        chain_q <= sync_d;
      end
    end

    assign sync_q = chain_q;
  end

  assign dest_out_gray = sync_q[DEST_SYNC_FF-1];
  assign dest_out_bin  = gray2bin(dest_out_gray);

`ifdef JELLY3_CDC_GRAY_LOSSLESS_CHK_EN
  function automatic logic multi_bit(input logic [WIDTH-1:0] x);
    return |(x & (x - WIDTH'(1)));
  endfunction

  logic [WIDTH-1:0] prev_d;
  logic [WIDTH-1:0] prev_q;
  logic             err_d;
  logic             err_q;

  // Compare the last stage with its value one cycle earlier; any multi-bit step latches the error.
  always_comb begin
    prev_d = dest_out_gray;
    err_d  = err_q | multi_bit(dest_out_gray ^ prev_q);
  end

  // Step-checker state; the reset value is the baseline for the first compared change.
  always_ff @(posedge dest_clk or negedge dest_rst_n) begin
    if (!dest_rst_n) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      err_q  <= err_d;
    end
  end

  assign dest_gray_err = err_q;

`ifndef SYNTHESIS
  // Simulation report of the offending step.
  always_ff @(posedge dest_clk) begin
    if (dest_rst_n && multi_bit(dest_out_gray ^ prev_q)) begin
      $error("gray step lost: old=%h new=%h", prev_q, dest_out_gray);
    end
  end
`endif
`endif

`ifndef SYNTHESIS
  if (SIM_ASSERT_CHK != 0) begin : g_param_chk
    if ((DEST_SYNC_FF < 2) || (DEST_SYNC_FF > 10)) begin : g_bad_sync
      $error("DEST_SYNC_FF=%0d outside 2..10", DEST_SYNC_FF);
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("WIDTH=%0d must be at least 1", WIDTH);
    end
  end
`endif

endmodule

// File: tb/tb_jelly3_cdc_gray_dest.sv
// Self-checking bench for jelly3_cdc_gray_dest: vector table plus scoreboard queues for three parameter sets.
module tb_jelly3_cdc_gray_dest;

  localparam int DSF   = 4;
  localparam int DSF16 = 2;
  localparam int DSF1  = 10;

  typedef struct packed {
    logic [7:0] bin;
    logic [7:0] gray;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  gin;
  logic [7:0]  obin;
  logic [7:0]  ogray;
  logic [15:0] gin16;
  logic [15:0] obin16;
  logic [15:0] ogray16;
  logic        gin1;
  logic        obin1;
  logic        ogray1;
`ifdef JELLY3_CDC_GRAY_LOSSLESS_CHK_EN
  logic        err8;
  logic        err16;
  logic        err1;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  vec_t        q8[$];
  logic [15:0] q16[$];
  logic        q1[$];
  vec_t        tbl[12];

  always #5 clk = ~clk;

  jelly3_cdc_gray_dest #(.WIDTH(8), .DEST_SYNC_FF(DSF), .DEVICE("RTL"), .SIM_ASSERT_CHK(1)) dut (
    .dest_clk(clk), .dest_rst_n(rst_n), .src_in_gray(gin),
    .dest_out_bin(obin), .dest_out_gray(ogray)
`ifdef JELLY3_CDC_GRAY_LOSSLESS_CHK_EN
    , .dest_gray_err(err8)
`endif
  );

  jelly3_cdc_gray_dest #(.WIDTH(16), .DEST_SYNC_FF(DSF16), .DEVICE("XILINX"), .SIM_ASSERT_CHK(1)) dut16 (
    .dest_clk(clk), .dest_rst_n(rst_n), .src_in_gray(gin16),
    .dest_out_bin(obin16), .dest_out_gray(ogray16)
`ifdef JELLY3_CDC_GRAY_LOSSLESS_CHK_EN
    , .dest_gray_err(err16)
`endif
  );

  jelly3_cdc_gray_dest #(.WIDTH(1), .DEST_SYNC_FF(DSF1), .DEVICE("RTL"), .SIM_ASSERT_CHK(1)) dut1 (
    .dest_clk(clk), .dest_rst_n(rst_n), .src_in_gray(gin1),
    .dest_out_bin(obin1), .dest_out_gray(ogray1)
`ifdef JELLY3_CDC_GRAY_LOSSLESS_CHK_EN
    , .dest_gray_err(err1)
`endif
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prefill8();
    vec_t z;
    z = '0;
    q8.delete();
    for (int i = 0; i < DSF - 1; i++) q8.push_back(z);
  endtask

  // Drive one gray word for one destination cycle and retire the scoreboard head.
  task automatic drive(input vec_t v);
    vec_t e;
    gin = v.gray;
    tick();
    q8.push_back(v);
    if (q8.size() >= DSF) begin
      e = q8.pop_front();
      check("bin8", {8'h00, obin}, {8'h00, e.bin});
      check("gray8", {8'h00, ogray}, {8'h00, e.gray});
    end
  endtask

  function automatic vec_t mk(input logic [7:0] b);
    vec_t v;
    v.bin  = b;
    v.gray = b ^ (b >> 1);
    return v;
  endfunction

  initial begin
    int n;
    logic [7:0] b;

    tbl[0]  = '{bin: 8'h00, gray: 8'h00};
    tbl[1]  = '{bin: 8'h01, gray: 8'h01};
    tbl[2]  = '{bin: 8'h02, gray: 8'h03};
    tbl[3]  = '{bin: 8'h03, gray: 8'h02};
    tbl[4]  = '{bin: 8'h5A, gray: 8'h77};
    tbl[5]  = '{bin: 8'hA5, gray: 8'hF7};
    tbl[6]  = '{bin: 8'h7F, gray: 8'h40};
    tbl[7]  = '{bin: 8'h80, gray: 8'hC0};
    tbl[8]  = '{bin: 8'hFE, gray: 8'h81};
    tbl[9]  = '{bin: 8'hFF, gray: 8'h80};
    tbl[10] = '{bin: 8'h00, gray: 8'h00};
    tbl[11] = '{bin: 8'hFF, gray: 8'h80};

    // Reset held with a live input: outputs stay zero.
    rst_n = 1'b0;
    gin   = 8'h77;
    gin16 = 16'h0000;
    gin1  = 1'b0;
    #1;
    check("rst_bin_async", {8'h00, obin}, 16'h0000);
    repeat (3) tick();
    check("rst_bin", {8'h00, obin}, 16'h0000);
    check("rst_gray", {8'h00, ogray}, 16'h0000);
    check("rst_bin16", obin16, 16'h0000);
    check("rst_bin1", {15'h0, obin1}, 16'h0000);

    // Release: 0x5A shows up on the fourth edge and stays.
    rst_n = 1'b1;
    prefill8();
    repeat (8) drive(tbl[4]);

    for (int i = 0; i < 12; i++) drive(tbl[i]);
    repeat (DSF + 2) drive(tbl[11]);

    // Slow-to-fast counting: each source count held two destination cycles, up then down.
    b = 8'hFF;
    for (int i = 0; i < 300; i++) begin
      b = b + 8'd1;
      drive(mk(b));
      drive(mk(b));
    end
    for (int i = 0; i < 300; i++) begin
      b = b - 8'd1;
      drive(mk(b));
      drive(mk(b));
    end
    repeat (DSF) drive(mk(b));
    check("count_end", {8'h00, obin}, {8'h00, b});

    // Asynchronous reset landing between edges while counting.
    for (int i = 0; i < 6; i++) begin
      b = b + 8'd1;
      drive(mk(b));
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_bin", {8'h00, obin}, 16'h0000);
    check("mid_rst_gray", {8'h00, ogray}, 16'h0000);
    tick();
    check("mid_rst_hold", {8'h00, obin}, 16'h0000);
    rst_n = 1'b1;
    prefill8();

    // Wrap-around in both directions, single gray steps only.
    repeat (4) drive(mk(8'h00));
    repeat (2) drive(mk(8'hFF));
    repeat (2) drive(mk(8'hFE));
    repeat (2) drive(mk(8'hFF));
    repeat (2) drive(mk(8'h00));
    repeat (2) drive(mk(8'hFF));
    repeat (2) drive(mk(8'h00));
    repeat (DSF + 1) drive(mk(8'h00));
    check("wrap_end", {8'h00, obin}, 16'h0000);
`ifdef JELLY3_CDC_GRAY_LOSSLESS_CHK_EN
    check("err_clean", {15'h0, err8}, 16'h0000);
    gin = 8'h03;
    repeat (DSF + 1) tick();
    check("err_set", {15'h0, err8}, 16'h0001);
    gin = 8'h00;
    repeat (6) tick();
    check("err_sticky", {15'h0, err8}, 16'h0001);
    rst_n = 1'b0;
    #1;
    check("err_clr", {15'h0, err8}, 16'h0000);
    tick();
    rst_n = 1'b1;
    repeat (DSF + 1) tick();
`endif

    // WIDTH=16, DEST_SYNC_FF=2: every gray code decodes, latency two edges.
    q16.delete();
    for (int i = 0; i < DSF16 - 1; i++) q16.push_back(16'h0000);
    for (int i = 0; i < 65536 + DSF16; i++) begin
      logic [15:0] v;
      logic [15:0] e;
      v = (i < 65536) ? 16'(i) : 16'hFFFF;
      gin16 = v ^ (v >> 1);
      tick();
      q16.push_back(v);
      e = q16.pop_front();
      check("bin16", obin16, e);
      if (i[11:0] == 12'h0) check("gray16", ogray16, e ^ (e >> 1));
    end

    // WIDTH=1, DEST_SYNC_FF=10: random bits through the deep chain.
    q1.delete();
    for (int i = 0; i < DSF1 - 1; i++) q1.push_back(1'b0);
    for (int i = 0; i < 40; i++) begin
      logic e;
      gin1 = 1'($urandom_range(0, 1));
      tick();
      q1.push_back(gin1);
      e = q1.pop_front();
      check("bin1", {15'h0, obin1}, {15'h0, e});
      check("gray1", {15'h0, ogray1}, {15'h0, e});
    end
    gin1 = 1'b0;
    repeat (DSF1 + 2) tick();
    check("w1_settle", {15'h0, obin1}, 16'h0000);
    gin1 = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while ((obin1 !== 1'b1) && (n < 20));
    check("w1_latency", 16'(n), 16'(DSF1));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
